yscaler: RTL and testbench
==========================

# yscaler

Vertical nearest-neighbour scaler for an 8-bit AXI4-Stream video pipeline. It takes frames of `ori_width × ori_height` pixels and emits frames of `ori_width × scale_height` pixels: input lines are repeated (upscale) or dropped (downscale). Line width is unchanged; horizontal scaling belongs to a separate stage.

## Interface
- `C_PIXEL_WIDTH`, 8: tdata width.
- `C_RESO_WIDTH`, 12: width of every resolution port.
- `C_MAX_WIDTH`, 4096: line-buffer depth in pixels (≥ max `ori_width`).
- Clocking and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ori_width`, `ori_height`  in  C_RESO_WIDTH  input frame size (≥1).
- `scale_width`  in  C_RESO_WIDTH  unused here; output width = `ori_width`.
- `scale_height`  in  C_RESO_WIDTH  output line count (≥1).
- `S_AXIS_tdata/tvalid/tready/tuser/tlast`  in/in/out/in/in  C_PIXEL_WIDTH/1/1/1/1  input stream; tuser = start of frame (SOF), tlast = end of line (EOL).
- `M_AXIS_tdata/tvalid/tready/tuser/tlast`  out/out/in/out/out  same widths  output stream.

## Operation
- Size ports are latched on each accepted input SOF and held for that frame.
- Mapping: output line j (0-based) carries input line s(j) = floor(j·ori_height / scale_height). No divider. Keep `e` (+ori_height per emitted line, starts 0) and `t` (+scale_height per input line, starts scale_height). Emit the current input line while e < t, then advance to the next input line. Both accumulators are 2·C_RESO_WIDTH bits.
- Ping-pong line buffers (2 × C_MAX_WIDTH). Input fills one buffer while output drains the other; each buffer is released after its last required repeat.
- An input line with repeat count 0 is accepted and discarded without occupying a buffer.
- Input line length is counted by `ori_width`; input tlast is ignored.
- Beats before the first SOF are accepted and dropped.
- An accepted SOF at any time aborts the current frame:
  - buffers, counters and accumulators clear;
  - output stops after the current beat completes;
  - that beat becomes pixel 0 of line 0.
- After `ori_height` input lines are received, further non-SOF beats are dropped until the next SOF.
- Output markers:
  - M tuser = 1 only on pixel 0 of output line 0.
  - M tlast = 1 on pixel `ori_width`−1 of every output line.
- A frame ends after `scale_height` lines. M tvalid then stays 0 until the next frame's first line is buffered.

## Timing
- Reset values: M tvalid/tuser/tlast = 0, M tdata = 0, S tready = 0, all counters 0, both buffers empty. After reset, S tready = 1 (idle, dropping).
- S tready = 1 when a free buffer exists, or the line is being discarded, or the block is waiting for SOF.
- Store-and-forward per line: output line k may start the cycle after its source line's last pixel is written. Minimum latency is one line plus 2 cycles.
- M tvalid never depends on M tready combinationally. While stalled, tdata/tuser/tlast hold stable. The RAM read has 1-cycle latency and feeds a 2-entry output skid buffer, giving 1 beat/cycle sustained.
- Simultaneous input write and output read of different buffers in the same cycle are supported.
- `reset` mid-frame overrides everything next edge.

## Structure
- Shared package: `C_*` defaults, and the buffer-state enum EMPTY/FILLING/FULL/DRAINING.
- One sub-module `yscaler_linebuf`: simple dual-port RAM, registered read, one write port, one read port.
- Top level holds the accumulators, the buffer FSMs and the output skid buffer.

## Test plan
- Upscale 10×10 → 10×30, input pixel (r,c) = 10r+c: output line k (1..30) = 10·floor((k−1)/3)+c. tuser only on first beat; tlast every 10th beat; exactly 300 beats.
- Downscale 10×10 → 10×4: output lines are input rows 0, 2, 5, 7 (40 beats).
- Identity 10×10 → 10×10 with random tvalid and random tready: output equals input beat-for-beat, with no loss and no duplication.
- `ori_width` = 1 → `scale_height` 3: every output beat has tlast = 1.
- SOF injected mid-frame, then a clean 4×4 frame: output restarts with tuser on the new frame's first pixel, followed by the correct 4-wide lines.
- Reset asserted mid-output: next cycle M tvalid = 0; the next frame after release is correct.

Source files
------------

// File: rtl/yscaler_pkg.sv
// Shared constants and buffer-state encoding for the vertical scaler.
package yscaler_pkg;

    localparam int unsigned C_PIXEL_WIDTH_DEF = 8;
    localparam int unsigned C_RESO_WIDTH_DEF  = 12;
    localparam int unsigned C_MAX_WIDTH_DEF   = 4096;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } buf_state_t;

endpackage

// File: rtl/yscaler_if.sv
// AXI4-Stream video beat bundle (tuser = start of frame, tlast = end of line).
interface yscaler_if #(
    parameter int unsigned DW = yscaler_pkg::C_PIXEL_WIDTH_DEF
) ();
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;
    logic          tuser;
    logic          tlast;

    modport master (output tdata, tvalid, tuser, tlast, input tready);
    modport slave  (input tdata, tvalid, tuser, tlast, output tready);
endinterface

// File: rtl/yscaler_linebuf.sv
// Simple dual-port line RAM: one write port, one registered read port.
module yscaler_linebuf #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 8192,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/yscaler.sv
// Vertical nearest-neighbour scaler: repeats or drops whole input lines using
// ping-pong line buffers, with a 2-entry skid buffer on the output stream.
module yscaler
    import yscaler_pkg::*;
#(
    parameter int unsigned C_PIXEL_WIDTH = C_PIXEL_WIDTH_DEF,
    parameter int unsigned C_RESO_WIDTH  = C_RESO_WIDTH_DEF,
    parameter int unsigned C_MAX_WIDTH   = C_MAX_WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [C_RESO_WIDTH-1:0] ori_width,
    input  logic [C_RESO_WIDTH-1:0] ori_height,
    input  logic [C_RESO_WIDTH-1:0] scale_width,
    input  logic [C_RESO_WIDTH-1:0] scale_height,
    yscaler_if.slave                S_AXIS,
    yscaler_if.master               M_AXIS
);
    localparam int unsigned PW    = C_PIXEL_WIDTH;
    localparam int unsigned RW    = C_RESO_WIDTH;
    localparam int unsigned AW    = $clog2(C_MAX_WIDTH);
    localparam int unsigned ACC_W = 2 * RW;

    logic unused_in;
    assign unused_in = ^{scale_width, S_AXIS.tlast};

    logic             active_q, active_n;
    logic [RW-1:0]    w_q, w_n, h_q, h_n, s_q, s_n;
    logic [RW-1:0]    in_col_q, in_col_n, in_line_q, in_line_n;
    logic [ACC_W-1:0] e_in_q, e_in_n, t_in_q, t_in_n;
    logic             wr_sel_q, wr_sel_n, rd_sel_q, rd_sel_n;
    buf_state_t       buf_st_q [2];
    buf_state_t       buf_st_n [2];
    logic [ACC_W-1:0] buf_t_q [2];
    logic [ACC_W-1:0] buf_t_n [2];
    logic [RW-1:0]    rd_col_q, rd_col_n, out_line_q, out_line_n;
    logic [ACC_W-1:0] e_out_q, e_out_n;
    logic             rd_pend_q, rd_pend_n, pend_user_q, pend_user_n, pend_last_q, pend_last_n;
    logic             head_vld_q, head_vld_n, head_user_q, head_user_n, head_last_q, head_last_n;
    logic             tail_vld_q, tail_vld_n, tail_user_q, tail_user_n, tail_last_q, tail_last_n;
    logic [PW-1:0]    head_data_q, head_data_n, tail_data_q, tail_data_n;
    logic             s_tready_q, s_tready_n;

    logic             s_acc, sof, pop, push, can_issue, take, keep, keep_nx;
    logic [1:0]       occ_n;
    logic             wr_en, rd_en;
    logic [AW:0]      wr_addr, rd_addr;
    logic [PW-1:0]    rd_data;

    yscaler_linebuf #(.DW(PW), .DEPTH(2 * C_MAX_WIDTH), .AW(AW + 1)) u_linebuf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (S_AXIS.tdata),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Next-state: output read sequencing, skid buffer, then input write side.
    always_comb begin
        active_n = active_q;  w_n = w_q;  h_n = h_q;  s_n = s_q;
        in_col_n = in_col_q;  in_line_n = in_line_q;  e_in_n = e_in_q;  t_in_n = t_in_q;
        wr_sel_n = wr_sel_q;  rd_sel_n = rd_sel_q;  buf_st_n = buf_st_q;  buf_t_n = buf_t_q;
        rd_col_n = rd_col_q;  out_line_n = out_line_q;  e_out_n = e_out_q;
        rd_pend_n = 1'b0;  pend_user_n = pend_user_q;  pend_last_n = pend_last_q;
        head_vld_n = head_vld_q;  head_data_n = head_data_q;
        head_user_n = head_user_q;  head_last_n = head_last_q;
        tail_vld_n = tail_vld_q;  tail_data_n = tail_data_q;
        tail_user_n = tail_user_q;  tail_last_n = tail_last_q;
        wr_en = 1'b0;  wr_addr = '0;  rd_en = 1'b0;  rd_addr = '0;

        s_acc = S_AXIS.tvalid && s_tready_q;
        sof   = s_acc && S_AXIS.tuser;
        pop   = head_vld_q && M_AXIS.tready;
        push  = rd_pend_q && !sof;
        occ_n = 2'(head_vld_q) + 2'(tail_vld_q) + 2'(push) - 2'(pop);

        can_issue = !sof && active_q && (out_line_q < s_q) && (occ_n != 2'd2) &&
                    (buf_st_q[rd_sel_q] == FULL || buf_st_q[rd_sel_q] == DRAINING);
        if (can_issue) begin
            rd_en       = 1'b1;
            rd_addr     = {rd_sel_q, AW'(rd_col_q)};
            rd_pend_n   = 1'b1;
            pend_user_n = (out_line_q == '0) && (rd_col_q == '0);
            pend_last_n = (rd_col_q == w_q - RW'(1));
            buf_st_n[rd_sel_q] = DRAINING;
            if (rd_col_q == w_q - RW'(1)) begin
                rd_col_n   = '0;
                out_line_n = out_line_q + RW'(1);
                e_out_n    = e_out_q + ACC_W'(h_q);
                // Last repeat of this source line: hand the buffer back to the input.
                if (e_out_n >= buf_t_q[rd_sel_q]) begin
                    buf_st_n[rd_sel_q] = EMPTY;
                    rd_sel_n = ~rd_sel_q;
                end
            end else begin
                rd_col_n = rd_col_q + RW'(1);
            end
        end

        if (pop) begin
            head_vld_n = tail_vld_q || push;
            if (tail_vld_q) begin
                head_data_n = tail_data_q;  head_user_n = tail_user_q;  head_last_n = tail_last_q;
            end else if (push) begin
                head_data_n = rd_data;  head_user_n = pend_user_q;  head_last_n = pend_last_q;
            end
            tail_vld_n = tail_vld_q && push;
            if (tail_vld_q && push) begin
                tail_data_n = rd_data;  tail_user_n = pend_user_q;  tail_last_n = pend_last_q;
            end
        end else if (push) begin
            if (!head_vld_q) begin
                head_vld_n = 1'b1;
                head_data_n = rd_data;  head_user_n = pend_user_q;  head_last_n = pend_last_q;
            end else begin
                tail_vld_n = 1'b1;
                tail_data_n = rd_data;  tail_user_n = pend_user_q;  tail_last_n = pend_last_q;
            end
        end

        // A new frame flushes everything except a beat already on the bus.
        if (sof) begin
            head_vld_n = head_vld_q && !pop;
            tail_vld_n = 1'b0;
            active_n = 1'b1;  w_n = ori_width;  h_n = ori_height;  s_n = scale_height;
            in_col_n = '0;  in_line_n = '0;  e_in_n = '0;  t_in_n = ACC_W'(scale_height);
            wr_sel_n = 1'b0;  rd_sel_n = 1'b0;  buf_st_n = '{EMPTY, EMPTY};
            rd_col_n = '0;  out_line_n = '0;  e_out_n = '0;
        end

        // Downscale lines hold at most one repeat, so one accumulator step decides keep/drop.
        keep = (h_n <= s_n) || (e_in_n < t_in_n);
        take = s_acc && active_n && (in_line_n < h_n);
        if (take) begin
            if (keep) begin
                wr_en   = 1'b1;
                wr_addr = {wr_sel_n, AW'(in_col_n)};
                buf_st_n[wr_sel_n] = FILLING;
            end
            if (in_col_n == w_n - RW'(1)) begin
                in_col_n  = '0;
                in_line_n = in_line_n + RW'(1);
                if (keep) begin
                    buf_st_n[wr_sel_n] = FULL;
                    buf_t_n[wr_sel_n]  = t_in_n;
                    wr_sel_n = ~wr_sel_n;
                    if (h_n > s_n) e_in_n = e_in_n + ACC_W'(h_n);
                end
                t_in_n = t_in_n + ACC_W'(s_n);
            end else begin
                in_col_n = in_col_n + RW'(1);
            end
        end

        keep_nx    = (h_n <= s_n) || (e_in_n < t_in_n);
        s_tready_n = !active_n || (in_line_n >= h_n) || !keep_nx ||
                     (buf_st_n[wr_sel_n] == EMPTY) || (buf_st_n[wr_sel_n] == FILLING);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q <= 1'b0;  w_q <= '0;  h_q <= '0;  s_q <= '0;
            in_col_q <= '0;  in_line_q <= '0;  e_in_q <= '0;  t_in_q <= '0;
            wr_sel_q <= 1'b0;  rd_sel_q <= 1'b0;
            buf_st_q <= '{EMPTY, EMPTY};  buf_t_q <= '{'0, '0};
            rd_col_q <= '0;  out_line_q <= '0;  e_out_q <= '0;
            rd_pend_q <= 1'b0;  pend_user_q <= 1'b0;  pend_last_q <= 1'b0;
            head_vld_q <= 1'b0;  head_data_q <= '0;  head_user_q <= 1'b0;  head_last_q <= 1'b0;
            tail_vld_q <= 1'b0;  tail_data_q <= '0;  tail_user_q <= 1'b0;  tail_last_q <= 1'b0;
            s_tready_q <= 1'b0;
        end else begin
            active_q <= active_n;  w_q <= w_n;  h_q <= h_n;  s_q <= s_n;
            in_col_q <= in_col_n;  in_line_q <= in_line_n;  e_in_q <= e_in_n;  t_in_q <= t_in_n;
            wr_sel_q <= wr_sel_n;  rd_sel_q <= rd_sel_n;
            buf_st_q <= buf_st_n;  buf_t_q <= buf_t_n;
            rd_col_q <= rd_col_n;  out_line_q <= out_line_n;  e_out_q <= e_out_n;
            rd_pend_q <= rd_pend_n;  pend_user_q <= pend_user_n;  pend_last_q <= pend_last_n;
            head_vld_q <= head_vld_n;  head_data_q <= head_data_n;
            head_user_q <= head_user_n;  head_last_q <= head_last_n;
            tail_vld_q <= tail_vld_n;  tail_data_q <= tail_data_n;
            tail_user_q <= tail_user_n;  tail_last_q <= tail_last_n;
            s_tready_q <= s_tready_n;
        end
    end

    assign S_AXIS.tready = s_tready_q;
    assign M_AXIS.tvalid = head_vld_q;
    assign M_AXIS.tdata  = head_data_q;
    assign M_AXIS.tuser  = head_user_q;
    assign M_AXIS.tlast  = head_last_q;
endmodule

// File: tb/tb_yscaler.sv
// Scoreboard bench for yscaler: directed frames, expected lines from floor(j*H/S).
module tb_yscaler;
    import yscaler_pkg::*;

    localparam int unsigned PW = C_PIXEL_WIDTH_DEF;
    localparam int unsigned RW = C_RESO_WIDTH_DEF;

    typedef struct packed {
        logic [PW-1:0] d;
        logic          u;
        logic          l;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [RW-1:0] ori_width = '0, ori_height = '0, scale_width = '0, scale_height = '0;

    yscaler_if #(.DW(PW)) s_if ();
    yscaler_if #(.DW(PW)) m_if ();

    yscaler dut (
        .clk          (clk),
        .reset        (reset),
        .ori_width    (ori_width),
        .ori_height   (ori_height),
        .scale_width  (scale_width),
        .scale_height (scale_height),
        .S_AXIS       (s_if),
        .M_AXIS       (m_if)
    );

    always #5 clk = ~clk;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    bit    ignore_out = 1'b0;
    bit    rnd_ready  = 1'b0;
    bit    rnd_valid  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Output ready: always 1, or a coin flip per cycle in random mode.
    initial begin
        m_if.tready = 1'b1;
        forever begin
            @(posedge clk); #1;
            m_if.tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: every accepted output beat is popped against the scoreboard.
    initial begin
        beat_t got, exp;
        forever begin
            @(negedge clk);
            if (m_if.tvalid && m_if.tready && !ignore_out) begin
                got = {m_if.tdata, m_if.tuser, m_if.tlast};
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got %0h expected none at %0t", got, $time);
                end else begin
                    exp = exp_q.pop_front();
                    check("out_beat{data,user,last}", 32'(got), 32'(exp));
                end
            end
        end
    end

    task automatic send_beat(input logic [PW-1:0] d, input logic u, input logic l);
        int guard = 0;
        if (rnd_valid && $urandom_range(0, 1) == 1) begin
            s_if.tvalid = 1'b0;
            repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
        end
        s_if.tvalid = 1'b1;  s_if.tdata = d;  s_if.tuser = u;  s_if.tlast = l;
        @(negedge clk);
        while (!s_if.tready && guard < 2000) begin
            guard++;
            @(negedge clk);
        end
        if (!s_if.tready) begin
            n_checks++;
            n_fail++;
            $display("FAIL in_tready_timeout: got 0 expected 1 at %0t", $time);
        end
        @(posedge clk); #1;
        s_if.tvalid = 1'b0;  s_if.tuser = 1'b0;
    endtask

    task automatic set_size(input int w, input int h, input int s);
        ori_width = RW'(w);  ori_height = RW'(h);  scale_height = RW'(s);  scale_width = RW'(w);
    endtask

    // Full frame with pixel (r,c) = 10r+c; expected output line j is input row floor(j*h/s).
    task automatic send_frame(input int w, input int h, input int s);
        set_size(w, h, s);
        for (int j = 0; j < s; j++) begin
            int src;
            src = (j * h) / s;
            for (int c = 0; c < w; c++)
                exp_q.push_back({PW'(10 * src + c), (j == 0 && c == 0), (c == w - 1)});
        end
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
                send_beat(PW'(10 * r + c), (r == 0 && c == 0), (c == w - 1));
    endtask

    task automatic wait_drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 5000) begin
            guard++;
            @(negedge clk);
        end
        check("drain_remaining", 32'(exp_q.size()), 32'd0);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        int guard;
        s_if.tvalid = 1'b0;  s_if.tdata = '0;  s_if.tuser = 1'b0;  s_if.tlast = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_m_tvalid", 32'(m_if.tvalid), 32'd0);
        check("rst_m_tuser",  32'(m_if.tuser),  32'd0);
        check("rst_m_tlast",  32'(m_if.tlast),  32'd0);
        check("rst_m_tdata",  32'(m_if.tdata),  32'd0);
        check("rst_s_tready", 32'(s_if.tready), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("idle_s_tready", 32'(s_if.tready), 32'd1);

        // Beats before the first SOF are dropped.
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) send_beat(PW'(8'hA0 + i), 1'b0, 1'b0);

        // Upscale, then trailing non-SOF beats that must be dropped.
        send_frame(10, 10, 30);
        for (int i = 0; i < 3; i++) send_beat(PW'(8'hE0 + i), 1'b0, 1'b0);
        wait_drain();

        send_frame(10, 10, 4);
        wait_drain();

        rnd_valid = 1'b1;  rnd_ready = 1'b1;
        send_frame(10, 10, 10);
        wait_drain();
        rnd_valid = 1'b0;  rnd_ready = 1'b0;

        send_frame(1, 2, 3);
        wait_drain();

        // Aborted frame (line 0 never completes), then a clean 4x4 frame.
        set_size(8, 4, 4);
        send_beat(PW'(8'h77), 1'b1, 1'b0);
        send_beat(PW'(8'h78), 1'b0, 1'b0);
        send_beat(PW'(8'h79), 1'b0, 1'b0);
        send_frame(4, 4, 4);
        wait_drain();

        // Reset while output is streaming.
        ignore_out = 1'b1;
        set_size(10, 10, 30);
        for (int i = 0; i < 20; i++) send_beat(PW'(i), (i == 0), 1'b0);
        guard = 0;
        @(negedge clk);
        while (!m_if.tvalid && guard < 200) begin
            guard++;
            @(negedge clk);
        end
        check("stream_started", 32'(m_if.tvalid), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("reset_mid_m_tvalid", 32'(m_if.tvalid), 32'd0);
        check("reset_mid_s_tready", 32'(s_if.tready), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        ignore_out = 1'b0;
        @(posedge clk); #1;
        send_frame(4, 4, 8);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
